// File: rtl/resp_pkg.sv
// resp_pkg: shared state encoding, frame sizing and default sync byte for the response serializer
package resp_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, DONE} resp_state_t;
  localparam int MAX_FRAME_BYTES = 7;
  typedef logic [$clog2(MAX_FRAME_BYTES)-1:0] frame_idx_t;
  localparam logic [7:0] DEFAULT_SYNC = 8'hAA;
endpackage

// File: rtl/resp_watchdog.sv
// resp_watchdog: saturating per-byte wait counter; expired flags the cycle that aborts the frame
module resp_watchdog #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);
  localparam logic [W-1:0] SAT = W'(TIMEOUT_CYCLES);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clear ? '0 : (enable && cnt_q != SAT) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clock) cnt_q <= reset ? '0 : cnt_d;
  assign expired = enable && cnt_q >= LIMIT;
endmodule

// File: rtl/resp_serializer.sv
// resp_serializer: frames a response word as SYNC, opcode, payload (MSB first) and paces bytes to the UART.
// Define RESP_CHECKSUM_EN to append an XOR checksum byte over opcode and payload.
module resp_serializer
  import resp_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC,
  parameter int         PAYLOAD_BYTES  = 4,
  parameter int         TIMEOUT_CYCLES = 200000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [7:0]  resp_opcode,
  input  logic [31:0] resp_data,
  output logic [7:0]  tx_byte,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic        busy,
  output logic        frame_done,
  output logic        timeout_err
);
`ifdef RESP_CHECKSUM_EN
  localparam int FRAME_LEN = 3 + PAYLOAD_BYTES;
`else
  localparam int FRAME_LEN = 2 + PAYLOAD_BYTES;
`endif
  localparam frame_idx_t LAST = frame_idx_t'(FRAME_LEN - 1);
  localparam frame_idx_t PAY_TOP = frame_idx_t'(PAYLOAD_BYTES + 1);
  resp_state_t state_q, state_d;
  frame_idx_t idx_q, idx_d;
  logic [7:0] op_q, op_d, tx_byte_q, tx_byte_d, frame_byte;
  logic [31:0] data_q, data_d;
  logic [1:0] pay_sel;
  logic tx_start_q, tx_start_d, timeout_err_q, timeout_err_d, wd_clear, wd_expired;
  // payload bytes go out MSB first, so frame index 2 maps to the highest sent byte
  assign pay_sel = 2'(PAY_TOP - idx_q);
`ifdef RESP_CHECKSUM_EN
  logic [7:0] csum;
  always_comb begin
    csum = op_q;
    for (int i = 0; i < PAYLOAD_BYTES; i++) csum = csum ^ data_q[8*i +: 8];
  end
  assign frame_byte = idx_q == LAST ? csum : idx_q == 3'd0 ? SYNC_BYTE :
                      idx_q == 3'd1 ? op_q : data_q[{pay_sel, 3'b000} +: 8];
`else
  assign frame_byte = idx_q == 3'd0 ? SYNC_BYTE : idx_q == 3'd1 ? op_q :
                      data_q[{pay_sel, 3'b000} +: 8];
`endif
  resp_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (state_q == WAIT_BUSY || state_q == WAIT_IDLE),
    .expired (wd_expired)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    op_d = op_q;
    data_d = data_q;
    tx_byte_d = tx_byte_q;
    tx_start_d = 1'b0;
    timeout_err_d = 1'b0;
    wd_clear = 1'b0;
    case (state_q)
      IDLE: if (resp_valid) begin
        op_d = resp_opcode;
        data_d = resp_data;
        idx_d = '0;
        state_d = ISSUE;
      end
      ISSUE: if (!tx_busy) begin
        tx_byte_d = frame_byte;
        tx_start_d = 1'b1;
        wd_clear = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: if (tx_busy) state_d = WAIT_IDLE;
      WAIT_IDLE: if (!tx_busy) begin
        state_d = idx_q == LAST ? DONE : ISSUE;
        idx_d = idx_q == LAST ? idx_q : idx_q + 3'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (wd_expired) begin
      state_d = IDLE;
      timeout_err_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q <= '0;
      op_q <= '0;
      data_q <= '0;
      tx_byte_q <= '0;
      tx_start_q <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      op_q <= op_d;
      data_q <= data_d;
      tx_byte_q <= tx_byte_d;
      tx_start_q <= tx_start_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign resp_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign frame_done = state_q == DONE;
  assign tx_byte = tx_byte_q;
  assign tx_start = tx_start_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_resp_serializer.sv
// tb_resp_serializer: scoreboard of expected frame bytes plus a simple UART busy model
module tb_resp_serializer;
  localparam int PB = 4;
  localparam int TO = 24;
`ifdef RESP_CHECKSUM_EN
  localparam int FL = PB + 3;
`else
  localparam int FL = PB + 2;
`endif
  logic clock = 1'b0, reset = 1'b1, resp_valid = 1'b0, tx_busy = 1'b0;
  logic [7:0] resp_opcode = '0;
  logic [31:0] resp_data = '0;
  logic resp_ready, tx_start, busy, frame_done, timeout_err;
  logic [7:0] tx_byte;
  resp_serializer #(.SYNC_BYTE(8'hAA), .PAYLOAD_BYTES(PB), .TIMEOUT_CYCLES(TO)) dut (
    .clock       (clock),
    .reset       (reset),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_opcode (resp_opcode),
    .resp_data   (resp_data),
    .tx_byte     (tx_byte),
    .tx_start    (tx_start),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err)
  );
  always #5 clock = ~clock;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$], log_q[$];
  int cyc = 0, gap = 100, done_cnt = 0, to_cnt = 0, strobe_cnt = 0, frame_strobes = 0;
  int last_strobe_cyc = 0, to_cyc = 0;
  logic [7:0] last_byte = '0;
  logic rst_edge = 1'b1, busy_edge = 1'b0, ready_due = 1'b0, ub;
  logic stuck = 1'b0, force_busy = 1'b0;
  int uart_len = 10, uart_cnt = 0;
  logic [7:0] lit_a [7] = '{8'hAA, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'h92};
  logic [7:0] lit_d [7] = '{8'hAA, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h5E};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  function automatic void push_frame(input logic [7:0] op, input logic [31:0] data);
    logic [31:0] sh;
`ifdef RESP_CHECKSUM_EN
    logic [7:0] cs;
    cs = op;
`endif
    exp_q.push_back(8'hAA);
    exp_q.push_back(op);
    for (int k = 0; k < PB; k++) begin
      sh = data >> (8 * (PB - 1 - k));
      exp_q.push_back(sh[7:0]);
`ifdef RESP_CHECKSUM_EN
      cs = cs ^ sh[7:0];
`endif
    end
`ifdef RESP_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction
  // UART: busy rises the edge after it sees a strobe and stays up uart_len cycles
  initial forever begin
    @(posedge clock);
    #1;
    ub = 1'b0;
    if (!stuck && uart_cnt > 0) begin
      ub = 1'b1;
      uart_cnt--;
    end
    if (!stuck && tx_start) uart_cnt = uart_len;
    tx_busy = ub | force_busy;
  end
  always @(posedge clock) begin
    rst_edge <= reset;
    busy_edge <= tx_busy;
  end
  always @(negedge clock) begin
    cyc++;
    gap++;
    if (rst_edge) begin
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_resp_ready", resp_ready, 1);
      exp_q.delete();
      last_byte = '0;
      gap = 100;
      ready_due = 1'b0;
    end else begin
      chk("ready_vs_busy", resp_ready, !busy);
      if (ready_due) chk("ready_after_done", resp_ready, 1);
      ready_due = frame_done;
      if (tx_start) begin
        chk("strobe_gap_ge3", gap >= 3, 1);
        chk("busy_low_at_strobe", busy_edge, 0);
        chk("strobe_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("tx_byte", tx_byte, exp_q.pop_front());
        last_byte = tx_byte;
        gap = 0;
        strobe_cnt++;
        frame_strobes++;
        last_strobe_cyc = cyc;
        log_q.push_back(tx_byte);
      end else chk("tx_byte_hold", tx_byte, last_byte);
      if (frame_done) begin
        chk("done_all_sent", exp_q.size(), 0);
        done_cnt++;
      end
      if (timeout_err) begin
        chk("timeout_idle", busy, 0);
        exp_q.delete();
        to_cnt++;
        to_cyc = cyc;
      end
      chk("done_xor_timeout", frame_done & timeout_err, 0);
    end
    if (resp_valid && resp_ready && !reset) begin
      chk("accept_queue_empty", exp_q.size(), 0);
      push_frame(resp_opcode, resp_data);
      frame_strobes = 0;
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send_word(input logic [7:0] op, input logic [31:0] data);
    int n = 0;
    resp_opcode = op;
    resp_data = data;
    resp_valid = 1'b1;
    while (!resp_ready && n < 1000) begin
      tick();
      n++;
    end
    chk("accept_bound", n < 1000, 1);
    tick();
    resp_valid = 1'b0;
  endtask
  task automatic wait_end();
    int d0 = done_cnt, t0 = to_cnt, n = 0;
    while (done_cnt == d0 && to_cnt == t0 && n < 3000) begin
      tick();
      n++;
    end
    chk("frame_end_bound", n < 3000, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1);
  end
  initial begin
    int d, t, s, n;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("post_reset_ready", resp_ready, 1);
    chk("post_reset_start", tx_start, 0);
    chk("post_reset_byte", tx_byte, 0);
    log_q.delete();
    d = done_cnt;
    send_word(8'h12, 32'h3456789A);
    tick();
    chk("first_latency_start", tx_start, 1);
    chk("first_byte", tx_byte, 8'hAA);
    wait_end();
    chk("a_ready_after", resp_ready, 1);
    chk("a_len", log_q.size(), FL);
    for (int i = 0; i < FL && i < log_q.size(); i++) chk("a_byte", log_q[i], lit_a[i]);
    chk("a_done_once", done_cnt - d, 1);
    @(negedge clock);
    force_busy = 1'b1;
    tick();
    tick();
    log_q.delete();
    send_word(8'hC3, 32'h0BADF00D);
    repeat (4) begin
      tick();
      chk("held_no_strobe", tx_start, 0);
      chk("held_busy", busy, 1);
    end
    @(negedge clock);
    force_busy = 1'b0;
    tick();
    chk("release_no_strobe_yet", tx_start, 0);
    tick();
    chk("release_strobe", tx_start, 1);
    chk("release_byte", tx_byte, 8'hAA);
    wait_end();
    chk("b_len", log_q.size(), FL);
    @(negedge clock);
    stuck = 1'b1;
    tick();
    d = done_cnt;
    t = to_cnt;
    send_word(8'h77, 32'h11223344);
    wait_end();
    chk("c_timeout_pulse", to_cnt - t, 1);
    chk("c_no_done", done_cnt - d, 0);
    chk("c_timeout_delay", to_cyc - last_strobe_cyc, TO);
    chk("c_busy_low", busy, 0);
    s = strobe_cnt;
    repeat (40) tick();
    chk("c_no_more_strobes", strobe_cnt - s, 0);
    chk("c_single_strobe", frame_strobes, 1);
    @(negedge clock);
    stuck = 1'b0;
    tick();
    send_word(8'($urandom), $urandom);
    n = 0;
    while (frame_strobes < 3 && n < 2000) begin
      tick();
      n++;
    end
    chk("d_third_byte_bound", n < 2000, 1);
    reset = 1'b1;
    tick();
    chk("d_rst_start", tx_start, 0);
    chk("d_rst_byte", tx_byte, 0);
    chk("d_rst_busy", busy, 0);
    reset = 1'b0;
    s = strobe_cnt;
    repeat (20) tick();
    chk("d_no_stale_strobe", strobe_cnt - s, 0);
    log_q.delete();
    send_word(8'h5A, 32'h01020304);
    wait_end();
    chk("d_len", log_q.size(), FL);
    for (int i = 0; i < FL && i < log_q.size(); i++) chk("d_byte", log_q[i], lit_d[i]);
    for (int f = 0; f < 30; f++) begin
      uart_len = $urandom_range(1, 10);
      repeat ($urandom_range(0, 3)) tick();
      d = done_cnt;
      send_word(8'($urandom), $urandom);
      wait_end();
      chk("e_done", done_cnt - d, 1);
    end
    chk("total_timeouts", to_cnt, 1);
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
